// File: rtl/xrv_muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M unit.
`timescale 1ns/1ps
interface xrv_muldiv_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [2:0]      optype;
  logic            valid;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic            busy;

  modport master (
    output a, b, optype, valid,
    input  result, result_valid, busy
  );

  modport slave (
    input  a, b, optype, valid,
    output result, result_valid, busy
  );
endinterface

// File: rtl/xrv_muldiv.sv
// RV32M multiply/divide unit: single-cycle multiplier beside a fixed-latency
// radix-2 restoring divider. One result_valid pulse per accepted operation.
`timescale 1ns/1ps
module xrv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rstb,
  xrv_muldiv_if.slave  bus
);

  localparam int              CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN);

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;

  logic busy;
  logic accept;
  logic accept_mul;
  logic accept_div;
  logic div_done;

  logic            op_signed;
  logic            a_neg;
  logic            b_neg;

  logic            vld_p0;
  logic [XLEN-1:0] mul_a_p0;
  logic [XLEN-1:0] mul_b_p0;
  logic [1:0]      mul_op_p0;

  logic [XLEN-1:0] rem_p0;
  logic [XLEN-1:0] quo_p0;
  logic [XLEN-1:0] dsr_p0;
  logic            q_neg_p0;
  logic            r_neg_p0;
  logic            dzero_p0;
  logic            is_rem_p0;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;

  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] div_res;
  logic [XLEN-1:0] result_p1;
  logic            vld_p1;

  // Low 2*XLEN bits of the product of sign- or zero-extended operands; the
  // truncated two's-complement product equals the exact product modulo 2^64.
  function automatic logic [XLEN-1:0] mul_word(input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y,
                                               input logic [1:0]      op);
    logic signed [2*XLEN-1:0] xs;
    logic signed [2*XLEN-1:0] ys;
    logic signed [2*XLEN-1:0] prod;
    xs   = {{XLEN{(op != 2'd3) & x[XLEN-1]}}, x};
    ys   = {{XLEN{(op[1] == 1'b0) & y[XLEN-1]}}, y};
    prod = xs * ys;
    mul_word = (op == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x,
                                              input logic            neg);
    abs_val = neg ? -x : x;
  endfunction

  // Sign restoration and RISC-V special cases. With a zero divisor the
  // restoring loop leaves |a| as remainder, so re-signing it returns a.
  // Signed overflow falls out naturally: |a|/1 = 0x80000000, remainder 0.
  function automatic logic [XLEN-1:0] div_word(input logic [XLEN-1:0] q,
                                               input logic [XLEN-1:0] r,
                                               input logic            qn,
                                               input logic            rn,
                                               input logic            dz,
                                               input logic            is_rem);
    if (is_rem)
      div_word = rn ? -r : r;
    else if (dz)
      div_word = '1;
    else
      div_word = qn ? -q : q;
  endfunction

  // busy drops in the cycle before the finishing edge so a new request can
  // be taken on the same edge that retires the division.
  assign busy       = (state == S_DIV) && (cnt != LAST);
  assign div_done   = (state == S_DIV) && (cnt == LAST);
  assign accept     = bus.valid && !busy;
  assign accept_mul = accept && !bus.optype[2];
  assign accept_div = accept &&  bus.optype[2];

  assign op_signed  = !bus.optype[0];
  assign a_neg      = op_signed && bus.a[XLEN-1];
  assign b_neg      = op_signed && bus.b[XLEN-1];

  assign rem_sh     = {rem_p0, quo_p0[XLEN-1]};
  assign rem_diff   = rem_sh - {1'b0, dsr_p0};

  assign mul_res    = mul_word(mul_a_p0, mul_b_p0, mul_op_p0);
  assign div_res    = div_word(quo_p0, rem_p0, q_neg_p0, r_neg_p0, dzero_p0, is_rem_p0);

  // Divider state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Divider next state: a request accepted on the finishing edge restarts it.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_div) state_nxt = S_DIV;
      S_DIV:   if (div_done)   state_nxt = accept_div ? S_DIV : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- stage p0: multiplier operand capture ----
  // Multiplier request valid.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) vld_p0 <= 1'b0;
    else       vld_p0 <= accept_mul;
  end

  // Multiplier operands, only loaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept_mul) begin
      mul_a_p0  <= bus.a;
      mul_b_p0  <= bus.b;
      mul_op_p0 <= bus.optype[1:0];
    end
  end

  // Divider: load magnitudes on accept, then one shift-subtract step per edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt       <= '0;
      rem_p0    <= '0;
      quo_p0    <= '0;
      dsr_p0    <= '0;
      q_neg_p0  <= 1'b0;
      r_neg_p0  <= 1'b0;
      dzero_p0  <= 1'b0;
      is_rem_p0 <= 1'b0;
    end else if (accept_div) begin
      cnt       <= '0;
      rem_p0    <= '0;
      quo_p0    <= abs_val(bus.a, a_neg);
      dsr_p0    <= abs_val(bus.b, b_neg);
      q_neg_p0  <= a_neg ^ b_neg;
      r_neg_p0  <= a_neg;
      dzero_p0  <= (bus.b == '0);
      is_rem_p0 <= bus.optype[1];
    end else if (busy) begin
      cnt    <= cnt + 1'b1;
      rem_p0 <= rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
      quo_p0 <= {quo_p0[XLEN-2:0], !rem_diff[XLEN]};
    end
  end

  // ---- stage p1: result register ----
  // Both paths can never finish on the same edge since multiplies are
  // refused while busy.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      result_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= div_done || vld_p0;
      if (div_done)    result_p1 <= div_res;
      else if (vld_p0) result_p1 <= mul_res;
    end
  end

  assign bus.result       = result_p1;
  assign bus.result_valid = vld_p1;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_xrv_muldiv.sv
// Scoreboard bench for xrv_muldiv: stimulus pushes expectations, an
// independent monitor pops and compares on every result_valid pulse.
`timescale 1ns/1ps
module tb_xrv_muldiv;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  xrv_muldiv_if #(.XLEN(32)) bif();

  xrv_muldiv #(.XLEN(32)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bif)
  );

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference model from the ISA definition using 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    longint          sa;
    longint          sb_;
    longint          ub;
    longint unsigned ua;
    longint unsigned uu;
    longint          p;
    longint unsigned pu;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ub  = longint'({32'h0, b});
    ua  = {32'h0, a};
    uu  = {32'h0, b};
    model = '0;
    case (op)
      3'd0: begin p = sa * sb_; model = p[31:0];  end
      3'd1: begin p = sa * sb_; model = p[63:32]; end
      3'd2: begin p = sa * ub;  model = p[63:32]; end
      3'd3: begin pu = ua * uu; model = pu[63:32]; end
      3'd4: begin if (b == 0) model = 32'hFFFFFFFF; else begin p = sa / sb_; model = p[31:0]; end end
      3'd5: begin if (b == 0) model = 32'hFFFFFFFF; else model = a / b; end
      3'd6: begin if (b == 0) model = a; else begin p = sa % sb_; model = p[31:0]; end end
      default: begin if (b == 0) model = a; else model = a % b; end
    endcase
  endfunction

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rstb === 1'b1 && bif.result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got result 0x%08h at cycle %0d, required no pulse",
                 bif.result, cyc);
      end else begin
        e = sb.pop_front();
        check32("result", bif.result, e.val);
        checki("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a falling edge; request is sampled at the next rising edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input bit push, input logic [31:0] expv);
    exp_t e;
    bif.a      = a;
    bif.b      = b;
    bif.optype = op;
    bif.valid  = 1'b1;
    if (push) begin
      e.val = expv;
      e.cyc = cyc + 1 + (op[2] ? 33 : 1);
      sb.push_back(e);
    end
    @(negedge clk);
    bif.valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Division with busy profile check: high for 32 cycles, low before retire.
  task automatic div_timed(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [31:0] expv);
    int bad = 0;
    drive(a, b, op, 1'b1, expv);
    for (int j = 0; j <= 32; j++) begin
      if (j > 0) @(negedge clk);
      if (bif.busy !== (j < 32)) bad++;
    end
    checki("busy_window_errors", bad, 0);
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    int          sel;

    bif.a = '0; bif.b = '0; bif.optype = '0; bif.valid = 1'b0;
    rstb = 1'b0;
    repeat (10) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check32("reset_result", bif.result, 32'h0);
    check32("reset_result_valid", {31'h0, bif.result_valid}, 32'h0);
    check32("reset_busy", {31'h0, bif.busy}, 32'h0);

    // Multiplier, single ops and back-to-back
    drive(32'h00000007, 32'hFFFFFFFD, 3'd0, 1'b1, 32'hFFFFFFEB);
    wait_drain();
    drive(32'h80000000, 32'h80000000, 3'd1, 1'b1, 32'h40000000);
    wait_drain();
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 1'b1, 32'hFFFFFFFE);
    wait_drain();
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 1'b1, 32'hFFFFFFFF);
    wait_drain();
    drive(32'd3, 32'd5, 3'd0, 1'b1, 32'd15);
    drive(32'h00010000, 32'h00010000, 3'd3, 1'b1, 32'h00000001);
    drive(32'hFFFFFFFE, 32'd3, 3'd0, 1'b1, 32'hFFFFFFFA);
    wait_drain();

    // Divider with timing profile
    div_timed(32'hFFFFFFF9, 32'd2, 3'd4, 32'hFFFFFFFD);
    div_timed(32'hFFFFFFF9, 32'd2, 3'd6, 32'hFFFFFFFF);
    div_timed(32'hFFFFFFF9, 32'd2, 3'd5, 32'h7FFFFFFC);
    div_timed(32'hFFFFFFF9, 32'd2, 3'd7, 32'h00000001);

    // Divide by zero and signed overflow
    drive(32'd5, 32'd0, 3'd4, 1'b1, 32'hFFFFFFFF); wait_drain();
    drive(32'd5, 32'd0, 3'd5, 1'b1, 32'hFFFFFFFF); wait_drain();
    drive(32'd5, 32'd0, 3'd6, 1'b1, 32'd5);        wait_drain();
    drive(32'd5, 32'd0, 3'd7, 1'b1, 32'd5);        wait_drain();
    drive(32'h80000000, 32'hFFFFFFFF, 3'd4, 1'b1, 32'h80000000); wait_drain();
    drive(32'h80000000, 32'hFFFFFFFF, 3'd6, 1'b1, 32'h00000000); wait_drain();

    // MUL requested mid-division is dropped
    drive(32'd100, 32'd7, 3'd4, 1'b1, 32'd14);
    repeat (5) @(negedge clk);
    drive(32'd9, 32'd9, 3'd0, 1'b0, 32'd0);
    wait_drain();

    // MUL issued as busy falls is taken on the retiring edge
    drive(32'd100, 32'd7, 3'd6, 1'b1, 32'd2);
    repeat (32) @(negedge clk);
    check32("busy_low_before_retire", {31'h0, bif.busy}, 32'h0);
    drive(32'd3, 32'd5, 3'd0, 1'b1, 32'd15);
    wait_drain();

    // Reset in the middle of a division aborts it silently
    drive(32'd1000, 32'd3, 3'd4, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    rstb = 1'b0;
    repeat (10) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check32("abort_busy", {31'h0, bif.busy}, 32'h0);
    check32("abort_result_valid", {31'h0, bif.result_valid}, 32'h0);
    repeat (40) @(negedge clk);
    drive(32'd10, 32'd3, 3'd5, 1'b1, 32'd3);
    wait_drain();

    // Randomized ops against the model, one every 64 cycles
    for (int n = 0; n < 40; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'h0;
      if (sel == 1) rb = $urandom_range(1, 15);
      if (sel == 2) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      rop = 3'($urandom_range(0, 7));
      drive(ra, rb, rop, 1'b1, model(ra, rb, rop));
      repeat (63) @(negedge clk);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
